// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared encodings and address-field ranges for the RV32I
//               front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    typedef enum logic [1:0] {
        PCSRC_PC4    = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JALR   = 2'b10,
        PCSRC_RESET  = 2'b11
    } pcsrc_e;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [3:0]  BIOS_REGION = 4'h4;
    localparam logic [3:0]  IMEM_REGION = 4'h1;

    localparam int REGION_HI    = 31;
    localparam int REGION_LO    = 28;
    localparam int BIOS_ADDR_HI = 13;
    localparam int BIOS_ADDR_LO = 2;
    localparam int IMEM_ADDR_HI = 15;
    localparam int IMEM_ADDR_LO = 2;

    function automatic logic [3:0] region_of(input logic [31:0] pc);
        return pc[REGION_HI:REGION_LO];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_pc_sel.sv
// ============================================================================
// Module      : pc_sel
// Description : Next-PC multiplexer; redirects outrank hold, result is
//               always word aligned.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sel
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        rst,
    input  logic        hold,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] pc_f,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    output logic [31:0] next_pc
);

    logic [31:0] sel;

    always_comb begin
        sel = RESET_PC;
        if (!rst) begin
            case (pcsrc_e'(pcsrc))
                PCSRC_BRANCH: sel = branch_target;
                PCSRC_JALR:   sel = jalr_target;
                PCSRC_RESET:  sel = RESET_PC;
                default:      sel = hold ? pc_f : pc_f + 32'd4;
            endcase
        end
        next_pc = sel & ~32'd3;
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction-fetch stage: PC register, BIOS/IMEM
//               address generation, region decode and wrong-path kill.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP      = NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    output logic [11:0] bios_addr,
    input  logic [31:0] bios_dout,
    output logic [13:0] imem_addr,
    input  logic [31:0] imem_dout,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        killed,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
);

    logic [31:0] pc_f_q, pc_f_d;
    logic        boot_q, boot_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] next_pc;
    logic [31:0] ram_word;
    logic        unmapped;

    // The boot slot is killed, so the PC holds there to avoid losing the
    // instruction at RESET_PC.
    pc_sel #(
        .RESET_PC (RESET_PC)
    ) u_pc_sel (
        .rst           (rst),
        .hold          (stall | boot_q),
        .pcsrc         (pcsrc),
        .pc_f          (pc_f_q),
        .branch_target (branch_target),
        .jalr_target   (jalr_target),
        .next_pc       (next_pc)
    );

    always_comb begin
        bios_addr = next_pc[BIOS_ADDR_HI:BIOS_ADDR_LO];
        imem_addr = next_pc[IMEM_ADDR_HI:IMEM_ADDR_LO];

        ram_word = NOP;
        unmapped = 1'b1;
        case (region_of(pc_f_q))
            BIOS_REGION: begin
                ram_word = bios_dout;
                unmapped = 1'b0;
            end
            IMEM_REGION: begin
                ram_word = imem_dout;
                unmapped = 1'b0;
            end
            default: ;
        endcase

        killed   = rst | boot_q | (pcsrc != PCSRC_PC4) | unmapped;
        inst_out = killed ? NOP : ram_word;
        pc_out   = rst ? RESET_PC : pc_f_q;

        pc_f_d       = next_pc;
        boot_d       = 1'b0;
        fetch_cnt_d  = fetch_cnt_q + {31'd0, (~killed & ~stall)};
        bubble_cnt_d = bubble_cnt_q + {31'd0, (killed | stall)};

        fetch_cnt  = fetch_cnt_q;
        bubble_cnt = bubble_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q       <= RESET_PC;
            boot_q       <= 1'b1;
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            pc_f_q       <= pc_f_d;
            boot_q       <= boot_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 3-stage RV32I core.
- Sits directly upstream of the EX/MEM stall/hazard logic and consumes its `stall` and `pcsrc` outputs.
- Owns the PC register and drives synchronous-read addresses to the BIOS and IMEM block RAMs.
- Returns the fetched instruction and its PC to decode. On a redirect it kills the wrong-path instruction by inserting a NOP.

Parameters:
- RESET_PC, 32'h4000_0000, PC loaded on reset (BIOS base).
- NOP, 32'h0000_0013, instruction inserted on kill (`addi x0,x0,0`).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold request from the stall unit.
- pcsrc  input  2  next-PC select: 00 PC+4, 01 branch/JAL target, 10 JALR target, 11 RESET_PC (trap/restart).
- branch_target  input  32  PC-relative target from EX.
- jalr_target  input  32  register-relative target from EX.
- bios_addr  output  12  BIOS word address = next_pc[13:2].
- bios_dout  input  32  BIOS read data; one-cycle latency.
- imem_addr  output  14  IMEM word address = next_pc[15:2].
- imem_dout  input  32  IMEM read data; one-cycle latency.
- pc_out  output  32  PC of `inst_out` (= pc_f).
- inst_out  output  32  instruction to decode.
- killed  output  1  high when `inst_out` is a forced NOP.
- fetch_cnt  output  32  count of delivered non-killed instructions.
- bubble_cnt  output  32  count of stall or kill cycles.

Behaviour:
- State:
  - pc_f (32b): the PC whose RAM data is arriving this cycle.
  - fetch_cnt, bubble_cnt: 32-bit counters.
  - boot_q (1b): high for the first cycle after reset.
- next_pc (combinational), in priority order:
  1. rst → RESET_PC.
  2. pcsrc=01 → branch_target.
  3. pcsrc=10 → jalr_target.
  4. pcsrc=11 → RESET_PC.
  5. stall → pc_f.
  6. otherwise → pc_f+4 (mod 2^32, wraps).
  - next_pc[1:0] is always forced to 00.
- Redirect (pcsrc≠00) has priority over stall when both are asserted in the same cycle.
- bios_addr and imem_addr are both driven from next_pc every cycle, including during rst. This gives data for pc_f one cycle later.
- Region decode uses registered pc_f[31:28]:
  - 4'h4 → bios_dout.
  - 4'h1 → imem_dout.
  - any other value → NOP, with killed=1.
- Kill: killed=1 and inst_out=NOP when any of the following holds:
  - pcsrc≠00 in the same cycle (wrong-path slot), or
  - boot_q=1, or
  - the unmapped-region case above.
- pc_out = pc_f regardless of kill.
- Stall without redirect:
  - pc_f holds and the RAM re-reads the same address.
  - inst_out stays stable and is not killed.
  - Decode must not advance; the stall unit guarantees this.
- Reset (synchronous, active-high):
  - pc_f←RESET_PC, boot_q←1, counters←0.
  - While rst=1: inst_out=NOP, killed=1, pc_out=RESET_PC.
  - The cycle after rst deasserts: boot_q=1, so the output is still killed. boot_q then clears.
  - A mid-run rst overrides stall and pcsrc within one cycle.
- Counters (not updated while rst=1; both wrap at 2^32):
  - fetch_cnt increments when killed=0 and stall=0.
  - bubble_cnt increments when killed=1 or stall=1.
- Latency: one cycle from a pcsrc redirect to the target instruction appearing on inst_out.

Decomposition:
- Shared package `riscv_pkg`:
  - PCSRC_* encodings (00/01/10/11).
  - NOP_INST.
  - BIOS_REGION=4'h4 and IMEM_REGION=4'h1.
  - Address-field bit ranges.
- Optional sub-module `pc_sel`: the combinational next_pc mux. Everything else stays in fetch_stage.

Test Plan:
- Reset release: rst high 2 cycles then low; model BIOS with word=addr.
  - → first post-reset cycle: killed=1, pc_out=0x4000_0000.
  - → next cycle: inst_out=bios word 0; then pc_out=0x4000_0004, 0x4000_0008.
- Sequential fetch: 5 cycles with no stall or redirect.
  - → pc_out advances by 4 each cycle; fetch_cnt=5; bubble_cnt equals the boot-cycle count only.
- Stall: assert stall 3 cycles at pc 0x4000_0010.
  - → pc_out and inst_out hold; bubble_cnt+=3; bios_addr stays 0x004.
- Branch: pcsrc=01, branch_target=0x1000_0020.
  - → that cycle killed=1, inst_out=0x0000_0013.
  - → next cycle pc_out=0x1000_0020, inst_out=imem_dout for word 0x008.
- Simultaneous: stall=1 with pcsrc=10, jalr_target=0x1000_0103.
  - → redirect wins; next pc_out=0x1000_0100 (low bits cleared).
- Unmapped/wrap:
  - branch to 0x2000_0000 → killed=1 each cycle and PC advances.
  - mid-run rst → pc_out=0x4000_0000 next cycle and counters reset to 0.
